// File: rtl/knight_seq_pkg.sv
// Shared opcodes, headings, sequencer states and the knight-move leg encoder.
// SEQ_FANFARE_EN selects opcode 4'h5 (move with fanfare) for the X leg.
package knight_seq_pkg;

    localparam logic [3:0] OP_MOVE    = 4'h4;
    localparam logic [3:0] OP_FANFARE = 4'h5;

    localparam logic [7:0] HD_N = 8'h00;
    localparam logic [7:0] HD_W = 8'h3F;
    localparam logic [7:0] HD_S = 8'h7F;
    localparam logic [7:0] HD_E = 8'hBF;

`ifdef SEQ_FANFARE_EN
    localparam logic [3:0] OP_XLEG = OP_FANFARE;
`else
    localparam logic [3:0] OP_XLEG = OP_MOVE;
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_Y_ISSUE,
        S_Y_WAIT,
        S_X_ISSUE,
        S_X_WAIT,
        S_U_ISSUE,
        S_U_WAIT,
        S_ERR
    } seq_state_t;

    // Each knight move is |d|<=2 per axis; pos selects N/E versus S/W.
    function automatic logic [15:0] leg_cmd(input logic [2:0] idx, input logic is_x);
        logic       pos;
        logic [1:0] mag;
        pos = 1'b0;
        mag = 2'd0;
        case ({is_x, idx})
            4'b0_000, 4'b0_001: begin pos = 1'b1; mag = 2'd2; end
            4'b0_010, 4'b0_111: begin pos = 1'b1; mag = 2'd1; end
            4'b0_011, 4'b0_110: begin pos = 1'b0; mag = 2'd1; end
            4'b0_100, 4'b0_101: begin pos = 1'b0; mag = 2'd2; end
            4'b1_000, 4'b1_101: begin pos = 1'b1; mag = 2'd1; end
            4'b1_001, 4'b1_100: begin pos = 1'b0; mag = 2'd1; end
            4'b1_010, 4'b1_011: begin pos = 1'b0; mag = 2'd2; end
            4'b1_110, 4'b1_111: begin pos = 1'b1; mag = 2'd2; end
            default:            begin pos = 1'b0; mag = 2'd0; end
        endcase
        if (is_x)
            return {OP_XLEG, (pos ? HD_E : HD_W), 2'b00, mag};
        else
            return {OP_MOVE, (pos ? HD_N : HD_S), 2'b00, mag};
    endfunction

endpackage

// File: rtl/move_fifo.sv
// DEPTH x 3-bit move queue; pointers wrap naturally since DEPTH is a power of 2.
module move_fifo #(
    parameter int DEPTH = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push,
    input  logic       pop,
    input  logic       flush,
    input  logic [2:0] din,
    output logic [2:0] dout,
    output logic       full,
    output logic       empty
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [2:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic          do_push, do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    // A pop in the same cycle frees a slot, so a full FIFO still accepts the push.
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/knight_cmd_seq.sv
// Sequencer feeding cmd_proc: expands queued knight moves into Y/X legs, forwards host commands when idle.
// Build option SEQ_FANFARE_EN (see knight_seq_pkg) sets the X-leg opcode.
import knight_seq_pkg::*;

module knight_cmd_seq #(
    parameter int DEPTH        = 8,
    parameter int TIMEOUT_CLKS = 50_000_000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        move_wr,
    input  logic [2:0]  move_in,
    output logic        move_full,
    input  logic [15:0] uart_cmd,
    input  logic        uart_cmd_rdy,
    output logic        clr_uart_cmd_rdy,
    output logic [15:0] cmd,
    output logic        cmd_rdy,
    input  logic        clr_cmd_rdy,
    input  logic        send_resp,
    output logic        resp_fwd,
    output logic        tour_busy,
    output logic        seq_err,
    input  logic        err_clr
);
    localparam int TW = $clog2(TIMEOUT_CLKS + 1);

    seq_state_t    state_q, state_d;
    logic [15:0]   cmd_q, cmd_d;
    logic          cmd_rdy_q, clr_uart_q, clr_uart_d, resp_fwd_q, fwd_d, seq_err_q;
    logic [TW-1:0] tmo_cnt;
    logic          tmo_hit, tour_leg;
    logic [2:0]    idx_q, fifo_dout;
    logic          fifo_push, fifo_pop, fifo_flush, fifo_full, fifo_empty;

    move_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .flush (fifo_flush),
        .din   (move_in),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign fifo_push = move_wr && (state_q != S_ERR);
    // Fires on the edge where the counter reaches TIMEOUT_CLKS.
    assign tmo_hit   = (tmo_cnt >= TW'(TIMEOUT_CLKS - 1));
    assign tour_leg  = (state_q == S_Y_ISSUE) || (state_q == S_Y_WAIT) ||
                       (state_q == S_X_ISSUE) || (state_q == S_X_WAIT);

    always_comb begin
        state_d    = state_q;
        cmd_d      = cmd_q;
        fifo_pop   = 1'b0;
        fifo_flush = 1'b0;
        clr_uart_d = 1'b0;
        fwd_d      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!fifo_empty) begin
                    state_d  = S_Y_ISSUE;
                    fifo_pop = 1'b1;
                    cmd_d    = leg_cmd(fifo_dout, 1'b0);
                end else if (uart_cmd_rdy) begin
                    state_d    = S_U_ISSUE;
                    clr_uart_d = 1'b1;
                    cmd_d      = uart_cmd;
                end
            end
            S_Y_ISSUE: begin
                if (clr_cmd_rdy && send_resp) begin
                    state_d = S_X_ISSUE;
                    cmd_d   = leg_cmd(idx_q, 1'b1);
                end else if (clr_cmd_rdy) begin
                    state_d = S_Y_WAIT;
                end
            end
            S_Y_WAIT: begin
                if (send_resp) begin
                    state_d = S_X_ISSUE;
                    cmd_d   = leg_cmd(idx_q, 1'b1);
                end else if (tmo_hit) begin
                    state_d = S_ERR;
                end
            end
            S_X_ISSUE: begin
                if (clr_cmd_rdy && send_resp) begin
                    state_d = S_IDLE;
                    fwd_d   = fifo_empty;
                end else if (clr_cmd_rdy) begin
                    state_d = S_X_WAIT;
                end
            end
            S_X_WAIT: begin
                // Only the last leg of a tour is acknowledged to the host.
                if (send_resp) begin
                    state_d = S_IDLE;
                    fwd_d   = fifo_empty;
                end else if (tmo_hit) begin
                    state_d = S_ERR;
                end
            end
            S_U_ISSUE: begin
                if (clr_cmd_rdy && send_resp) begin
                    state_d = S_IDLE;
                    fwd_d   = 1'b1;
                end else if (clr_cmd_rdy) begin
                    state_d = S_U_WAIT;
                end
            end
            S_U_WAIT: begin
                if (send_resp) begin
                    state_d = S_IDLE;
                    fwd_d   = 1'b1;
                end else if (tmo_hit) begin
                    state_d = S_ERR;
                end
            end
            S_ERR: begin
                if (err_clr) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        if ((state_d == S_ERR) && (state_q != S_ERR)) fifo_flush = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            cmd_q      <= '0;
            cmd_rdy_q  <= 1'b0;
            clr_uart_q <= 1'b0;
            resp_fwd_q <= 1'b0;
            seq_err_q  <= 1'b0;
            tmo_cnt    <= '0;
            idx_q      <= '0;
        end else begin
            state_q    <= state_d;
            cmd_q      <= cmd_d;
            cmd_rdy_q  <= (state_d == S_Y_ISSUE) || (state_d == S_X_ISSUE) ||
                          (state_d == S_U_ISSUE);
            clr_uart_q <= clr_uart_d;
            resp_fwd_q <= fwd_d;
            seq_err_q  <= (state_d == S_ERR);
            if (fifo_pop) idx_q <= fifo_dout;
            if (((state_d == S_Y_WAIT) || (state_d == S_X_WAIT) || (state_d == S_U_WAIT)) &&
                (state_d != state_q))
                tmo_cnt <= '0;
            else if (tmo_cnt != TW'(TIMEOUT_CLKS))
                tmo_cnt <= tmo_cnt + TW'(1);
        end
    end

    assign cmd              = cmd_q;
    assign cmd_rdy          = cmd_rdy_q;
    assign clr_uart_cmd_rdy = clr_uart_q;
    assign resp_fwd         = resp_fwd_q;
    assign seq_err          = seq_err_q;
    assign move_full        = fifo_full;
    assign tour_busy        = !fifo_empty || tour_leg;

endmodule

// File: tb/tb_knight_cmd_seq.sv
// Scoreboard bench for knight_cmd_seq: expected commands queued at stimulus, compared as cmd_proc sees them.
module tb_knight_cmd_seq;

`ifdef SEQ_FANFARE_EN
    localparam logic [3:0] X_OP = 4'h5;
`else
    localparam logic [3:0] X_OP = 4'h4;
`endif
    localparam logic [15:0] Y_EXP [8] = '{16'h4002, 16'h4002, 16'h4001, 16'h47F1,
                                          16'h47F2, 16'h47F2, 16'h47F1, 16'h4001};
    localparam logic [11:0] X_LO  [8] = '{12'hBF1, 12'h3F1, 12'h3F2, 12'h3F2,
                                          12'h3F1, 12'hBF1, 12'hBF2, 12'hBF2};

    logic        clk = 1'b0, rst_n = 1'b0;
    logic        move_wr = 1'b0;
    logic [2:0]  move_in = '0;
    logic        move_full;
    logic [15:0] uart_cmd = '0;
    logic        uart_cmd_rdy = 1'b0, clr_uart_cmd_rdy;
    logic [15:0] cmd;
    logic        cmd_rdy, clr_cmd_rdy = 1'b0, send_resp = 1'b0;
    logic        resp_fwd, tour_busy, seq_err, err_clr = 1'b0;

    int          checks = 0, errors = 0;
    int          fwd_cnt = 0, clr_cnt = 0;
    logic [15:0] exp_q [$];
    logic [15:0] exp_v;
    bit          seen = 1'b0;

    knight_cmd_seq #(.DEPTH(8), .TIMEOUT_CLKS(100)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .move_wr          (move_wr),
        .move_in          (move_in),
        .move_full        (move_full),
        .uart_cmd         (uart_cmd),
        .uart_cmd_rdy     (uart_cmd_rdy),
        .clr_uart_cmd_rdy (clr_uart_cmd_rdy),
        .cmd              (cmd),
        .cmd_rdy          (cmd_rdy),
        .clr_cmd_rdy      (clr_cmd_rdy),
        .send_resp        (send_resp),
        .resp_fwd         (resp_fwd),
        .tour_busy        (tour_busy),
        .seq_err          (seq_err),
        .err_clr          (err_clr)
    );

    always #5 clk = ~clk;

    // Scoreboard: each newly presented command is popped and compared once.
    always @(negedge clk) begin
        if (!rst_n) begin
            seen = 1'b0;
        end else begin
            if (resp_fwd) fwd_cnt++;
            if (clr_uart_cmd_rdy) clr_cnt++;
            if (cmd_rdy && !seen) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL sb_unexpected: got cmd %h, required no command", cmd);
                end else begin
                    exp_v = exp_q.pop_front();
                    if (cmd !== exp_v) begin
                        errors++;
                        $display("FAIL sb_cmd: got %h, required %h", cmd, exp_v);
                    end
                end
                seen = 1'b1;
            end
            if (!cmd_rdy || clr_cmd_rdy) seen = 1'b0;
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_move(input int idx);
        exp_q.push_back(Y_EXP[idx]);
        exp_q.push_back({X_OP, X_LO[idx]});
    endtask

    task automatic push_move(input logic [2:0] idx);
        move_in = idx;
        move_wr = 1'b1;
        cyc(1);
        move_wr = 1'b0;
    endtask

    // cmd_proc side: wait for cmd_rdy, then take it with a one-cycle clr_cmd_rdy.
    task automatic hs();
        for (int i = 0; i < 50 && !cmd_rdy; i++) cyc(1);
        if (!cmd_rdy) begin
            errors++;
            $display("FAIL hs_wait: cmd_rdy %b, required 1 within 50 cycles", cmd_rdy);
        end
        clr_cmd_rdy = 1'b1;
        cyc(1);
        clr_cmd_rdy = 1'b0;
    endtask

    task automatic resp(input int dly);
        cyc(dly);
        send_resp = 1'b1;
        cyc(1);
        send_resp = 1'b0;
    endtask

    task automatic wait_clr_uart();
        for (int i = 0; i < 20 && !clr_uart_cmd_rdy; i++) cyc(1);
        checks++;
        if (clr_uart_cmd_rdy !== 1'b1) begin
            errors++;
            $display("FAIL clr_uart_wait: clr_uart_cmd_rdy %b, required 1", clr_uart_cmd_rdy);
        end
        uart_cmd_rdy = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        cyc(2);
        checks++;
        if ({cmd, cmd_rdy, clr_uart_cmd_rdy, resp_fwd, tour_busy, seq_err, move_full} !== 22'd0) begin
            errors++;
            $display("FAIL reset_outputs: cmd %h rdy %b clr %b fwd %b busy %b err %b full %b, required all 0",
                     cmd, cmd_rdy, clr_uart_cmd_rdy, resp_fwd, tour_busy, seq_err, move_full);
        end
        #3 rst_n = 1'b1;
        cyc(2);
    endtask

    task automatic test_uart();
        int f0, c0;
        f0 = fwd_cnt; c0 = clr_cnt;
        exp_q.push_back(16'h2000);
        uart_cmd = 16'h2000;
        uart_cmd_rdy = 1'b1;
        wait_clr_uart();
        send_resp = 1'b1;   // not in a WAIT state: must be ignored
        cyc(1);
        send_resp = 1'b0;
        checks++;
        if (cmd_rdy !== 1'b1 || fwd_cnt != f0) begin
            errors++;
            $display("FAIL uart_early_resp: cmd_rdy %b fwd %0d, required 1 and 0", cmd_rdy, fwd_cnt - f0);
        end
        hs();
        resp(2);
        cyc(3);
        checks++;
        if (fwd_cnt - f0 != 1 || clr_cnt - c0 != 1) begin
            errors++;
            $display("FAIL uart_pulses: resp_fwd %0d clr_uart %0d, required 1 and 1", fwd_cnt - f0, clr_cnt - c0);
        end
    endtask

    task automatic test_single_move();
        int f0;
        f0 = fwd_cnt;
        expect_move(7);
        push_move(3'd7);
        checks++;
        if (tour_busy !== 1'b1) begin
            errors++;
            $display("FAIL move_busy: tour_busy %b, required 1", tour_busy);
        end
        hs(); resp(2);
        hs(); resp(2);
        cyc(3);
        checks++;
        if (fwd_cnt - f0 != 1 || tour_busy !== 1'b0) begin
            errors++;
            $display("FAIL move_end: resp_fwd %0d busy %b, required 1 and 0", fwd_cnt - f0, tour_busy);
        end
    endtask

    task automatic test_lockout();
        int f0, c0;
        f0 = fwd_cnt; c0 = clr_cnt;
        expect_move(3);
        exp_q.push_back(16'h2345);
        push_move(3'd3);
        hs();
        uart_cmd = 16'h2345;
        uart_cmd_rdy = 1'b1;
        cyc(5);
        checks++;
        if (clr_cnt != c0 || cmd_rdy !== 1'b0) begin
            errors++;
            $display("FAIL lockout_ywait: clr_uart %0d cmd_rdy %b, required 0 and 0", clr_cnt - c0, cmd_rdy);
        end
        resp(1);
        hs();
        checks++;
        if (clr_cnt != c0) begin
            errors++;
            $display("FAIL lockout_x: clr_uart %0d, required 0", clr_cnt - c0);
        end
        resp(1);
        wait_clr_uart();
        hs();
        resp(1);
        cyc(3);
        checks++;
        if (fwd_cnt - f0 != 2 || clr_cnt - c0 != 1) begin
            errors++;
            $display("FAIL lockout_end: resp_fwd %0d clr_uart %0d, required 2 and 1", fwd_cnt - f0, clr_cnt - c0);
        end
    endtask

    task automatic test_fifo_full();
        int f0;
        f0 = fwd_cnt;
        exp_q.push_back(16'h2111);
        for (int i = 0; i < 8; i++) expect_move(i);
        uart_cmd = 16'h2111;
        uart_cmd_rdy = 1'b1;
        wait_clr_uart();    // held in U_ISSUE so nothing pops
        for (int k = 0; k < 9; k++) begin
            push_move(3'(k % 8));
            checks++;
            if (move_full !== (k >= 7)) begin
                errors++;
                $display("FAIL full_push%0d: move_full %b, required %b", k, move_full, (k >= 7));
            end
        end
        hs(); resp(1);
        for (int l = 0; l < 16; l++) begin
            hs(); resp(1);
        end
        cyc(5);
        checks++;
        if (cmd_rdy !== 1'b0 || tour_busy !== 1'b0 || fwd_cnt - f0 != 2) begin
            errors++;
            $display("FAIL full_drain: cmd_rdy %b busy %b resp_fwd %0d, required 0 0 2",
                     cmd_rdy, tour_busy, fwd_cnt - f0);
        end
    endtask

    task automatic test_timeout();
        exp_q.push_back(Y_EXP[5]);
        push_move(3'd5);
        push_move(3'd1);
        hs();               // returns 1ns after the handshake edge
        cyc(99);
        checks++;
        if (seq_err !== 1'b0) begin
            errors++;
            $display("FAIL tmo_early: seq_err %b at handshake+99, required 0", seq_err);
        end
        cyc(1);
        checks++;
        if (seq_err !== 1'b1 || cmd_rdy !== 1'b0 || tour_busy !== 1'b0) begin
            errors++;
            $display("FAIL tmo_hit: seq_err %b cmd_rdy %b busy %b at handshake+100, required 1 0 0",
                     seq_err, cmd_rdy, tour_busy);
        end
        push_move(3'd2);    // dropped while in ERR
        cyc(3);
        checks++;
        if (seq_err !== 1'b1 || tour_busy !== 1'b0) begin
            errors++;
            $display("FAIL tmo_sticky: seq_err %b busy %b, required 1 0", seq_err, tour_busy);
        end
        err_clr = 1'b1;
        cyc(1);
        err_clr = 1'b0;
        cyc(5);
        checks++;
        if (seq_err !== 1'b0 || cmd_rdy !== 1'b0 || tour_busy !== 1'b0) begin
            errors++;
            $display("FAIL tmo_clear: seq_err %b cmd_rdy %b busy %b, required 0 0 0", seq_err, cmd_rdy, tour_busy);
        end
    endtask

    task automatic test_same_cycle_reset();
        exp_q.push_back(Y_EXP[7]);
        push_move(3'd7);
        push_move(3'd2);
        for (int i = 0; i < 20 && !cmd_rdy; i++) cyc(1);
        clr_cmd_rdy = 1'b1;
        send_resp   = 1'b1;
        cyc(1);
        clr_cmd_rdy = 1'b0;
        send_resp   = 1'b0;
        checks++;
        if (cmd_rdy !== 1'b1 || cmd !== {X_OP, X_LO[7]}) begin
            errors++;
            $display("FAIL same_cycle: cmd_rdy %b cmd %h, required 1 %h", cmd_rdy, cmd, {X_OP, X_LO[7]});
        end
        #2 rst_n = 1'b0;
        #1;
        exp_q.delete();
        checks++;
        if ({cmd, cmd_rdy, clr_uart_cmd_rdy, resp_fwd, tour_busy, seq_err, move_full} !== 22'd0) begin
            errors++;
            $display("FAIL mid_reset: cmd %h rdy %b clr %b fwd %b busy %b err %b full %b, required all 0",
                     cmd, cmd_rdy, clr_uart_cmd_rdy, resp_fwd, tour_busy, seq_err, move_full);
        end
        cyc(2);
        #3 rst_n = 1'b1;
        cyc(5);
        checks++;
        if (tour_busy !== 1'b0 || cmd_rdy !== 1'b0) begin
            errors++;
            $display("FAIL reset_flush: busy %b cmd_rdy %b, required 0 0", tour_busy, cmd_rdy);
        end
    endtask

    initial begin
        test_reset();
        test_uart();
        test_single_move();
        test_lockout();
        test_fifo_full();
        test_timeout();
        test_same_cycle_reset();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL sb_leftover: %0d expected commands never issued, required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
